// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one AXI read per instruction, single outstanding fetch.
// Presents each fetched word with a one-cycle valid pulse, then waits for execute to request the next PC.
module ifu_fetch #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifetch_req,
    input  logic              ifetch_taken,
    input  logic [ADDR_W-1:0] ifetch_taken_pc,
    output logic              IFU_vld,
    output logic [ADDR_W-1:0] IFU_pc,
    output logic [31:0]       IFU_inst,
    output logic              proto_err,
    output logic [63:0]       inst_cnt,
    output logic [63:0]       axi_AR_ADDR,
    output logic              axi_AR_VALID,
    input  logic              axi_AR_READY,
    input  logic [63:0]       axi_R_DATA,
    input  logic              axi_R_VALID,
    output logic              axi_R_READY
);

    typedef enum logic [1:0] {S_AR, S_R, S_OUT, S_WAIT} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ifu_pc_q;
    logic [31:0]       ifu_inst_q;
    logic              ifu_vld_q;
    logic              proto_err_q;
    logic [63:0]       cnt_q;
    logic [31:0]       rword;

    // Redirect targets are forced to a 4-byte boundary.
    assign pc_d  = ifetch_taken ? {ifetch_taken_pc[ADDR_W-1:2], 2'b00} : pc_q + ADDR_W'(4);
    assign rword = pc_q[2] ? axi_R_DATA[63:32] : axi_R_DATA[31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_AR;
            pc_q        <= RESET_PC;
            ifu_pc_q    <= RESET_PC;
            ifu_inst_q  <= 32'h0;
            ifu_vld_q   <= 1'b0;
            proto_err_q <= 1'b0;
            cnt_q       <= 64'h0;
        end else begin
            case (state_q)
                S_AR: begin
                    if (ifetch_req) proto_err_q <= 1'b1;
                    if (axi_AR_READY) state_q <= S_R;
                end
                S_R: begin
                    if (ifetch_req) proto_err_q <= 1'b1;
                    if (axi_R_VALID) begin
                        ifu_inst_q <= rword;
                        ifu_pc_q   <= pc_q;
                        ifu_vld_q  <= 1'b1;
                        state_q    <= S_OUT;
                    end
                end
                S_OUT: begin
                    ifu_vld_q <= 1'b0;
                    cnt_q     <= cnt_q + 64'd1;
                    if (ifetch_req) begin
                        pc_q    <= pc_d;
                        state_q <= S_AR;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ifetch_req) begin
                        pc_q    <= pc_d;
                        state_q <= S_AR;
                    end
                end
                default: state_q <= S_AR;
            endcase
        end
    end

    // Handshake strobes are gated by rst so nothing is offered or accepted during reset.
    assign axi_AR_VALID = (state_q == S_AR) && !rst;
    assign axi_R_READY  = (state_q == S_R) && !rst;
    assign axi_AR_ADDR  = 64'({pc_q[ADDR_W-1:3], 3'b000});
    assign IFU_vld      = ifu_vld_q;
    assign IFU_pc       = ifu_pc_q;
    assign IFU_inst     = ifu_inst_q;
    assign proto_err    = proto_err_q;
    assign inst_cnt     = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: reset, sequential/redirect fetch, backpressure, protocol error, mid-fetch reset, PC wrap.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifetch_req, ifetch_taken;
    logic [63:0] ifetch_taken_pc;
    logic        IFU_vld;
    logic [63:0] IFU_pc;
    logic [31:0] IFU_inst;
    logic        proto_err;
    logic [63:0] inst_cnt;
    logic [63:0] axi_AR_ADDR;
    logic        axi_AR_VALID, axi_AR_READY;
    logic [63:0] axi_R_DATA;
    logic        axi_R_VALID, axi_R_READY;

    int checks = 0;
    int errors = 0;
    int n;

    ifu_fetch dut (
        .clk(clk), .rst(rst),
        .ifetch_req(ifetch_req), .ifetch_taken(ifetch_taken), .ifetch_taken_pc(ifetch_taken_pc),
        .IFU_vld(IFU_vld), .IFU_pc(IFU_pc), .IFU_inst(IFU_inst),
        .proto_err(proto_err), .inst_cnt(inst_cnt),
        .axi_AR_ADDR(axi_AR_ADDR), .axi_AR_VALID(axi_AR_VALID), .axi_AR_READY(axi_AR_READY),
        .axi_R_DATA(axi_R_DATA), .axi_R_VALID(axi_R_VALID), .axi_R_READY(axi_R_READY)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Steps until IFU_vld is seen (bounded), returning the number of edges taken.
    task automatic wait_vld(input string tag, output int cyc);
        cyc = 0;
        while (IFU_vld !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        chk({tag, "_vld"}, 64'(IFU_vld), 64'd1);
    endtask

    // Pulses ifetch_req for one sampling edge.
    task automatic req(input logic taken, input logic [63:0] tpc);
        ifetch_req = 1'b1; ifetch_taken = taken; ifetch_taken_pc = tpc;
        step();
        ifetch_req = 1'b0; ifetch_taken = 1'b0; ifetch_taken_pc = 64'h0;
    endtask

    initial begin
        rst = 1'b1; ifetch_req = 1'b0; ifetch_taken = 1'b0; ifetch_taken_pc = 64'h0;
        axi_AR_READY = 1'b1; axi_R_VALID = 1'b1; axi_R_DATA = 64'h00000013_00100093;
        repeat (3) step();
        chk("rst_arvalid", 64'(axi_AR_VALID), 64'd0);
        chk("rst_rready", 64'(axi_R_READY), 64'd0);
        chk("rst_vld", 64'(IFU_vld), 64'd0);
        chk("rst_pc", IFU_pc, 64'h8000_0000);
        chk("rst_inst", 64'(IFU_inst), 64'd0);
        chk("rst_cnt", inst_cnt, 64'd0);
        chk("rst_perr", 64'(proto_err), 64'd0);

        // First fetch after reset release
        rst = 1'b0;
        #1;
        chk("first_arvalid", 64'(axi_AR_VALID), 64'd1);
        chk("first_araddr", axi_AR_ADDR, 64'h8000_0000);
        wait_vld("first", n);
        chk("first_pc", IFU_pc, 64'h8000_0000);
        chk("first_inst", 64'(IFU_inst), 64'h0010_0093);
        step();
        chk("first_pulse", 64'(IFU_vld), 64'd0);
        chk("first_cnt", inst_cnt, 64'd1);

        // Sequential fetch: 3-cycle minimum latency, upper word
        req(1'b0, 64'h0);
        chk("seq_araddr", axi_AR_ADDR, 64'h8000_0000);
        wait_vld("seq", n);
        chk("seq_latency", 64'(n + 1), 64'd3);
        chk("seq_pc", IFU_pc, 64'h8000_0004);
        chk("seq_inst", 64'(IFU_inst), 64'h0000_0013);

        // Redirect to a misaligned target
        step();
        axi_R_DATA = 64'hDEADBEEF_0000006F;
        req(1'b1, 64'h8000_1006);
        chk("redir_araddr", axi_AR_ADDR, 64'h8000_1000);
        wait_vld("redir", n);
        chk("redir_pc", IFU_pc, 64'h8000_1004);
        chk("redir_inst", 64'(IFU_inst), 64'hDEAD_BEEF);
        step();
        chk("redir_cnt", inst_cnt, 64'd3);

        // Backpressure on AR then R; stray R_VALID while in S_AR must be ignored
        axi_AR_READY = 1'b0; axi_R_VALID = 1'b1; axi_R_DATA = 64'h11111111_22222222;
        req(1'b0, 64'h0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_arvalid", 64'(axi_AR_VALID), 64'd1);
            chk("bp_araddr", axi_AR_ADDR, 64'h8000_1008);
            chk("bp_rready_ar", 64'(axi_R_READY), 64'd0);
            chk("bp_vld_ar", 64'(IFU_vld), 64'd0);
            step();
        end
        axi_AR_READY = 1'b1; axi_R_VALID = 1'b0; axi_R_DATA = 64'h33333333_44444444;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("bp_rready", 64'(axi_R_READY), 64'd1);
            chk("bp_arvalid_r", 64'(axi_AR_VALID), 64'd0);
            chk("bp_vld_r", 64'(IFU_vld), 64'd0);
            chk("bp_hold_pc", IFU_pc, 64'h8000_1004);
            step();
        end
        axi_R_VALID = 1'b1;
        step();
        chk("bp_vld", 64'(IFU_vld), 64'd1);
        chk("bp_pc", IFU_pc, 64'h8000_1008);
        chk("bp_inst", 64'(IFU_inst), 64'h4444_4444);
        step();
        chk("bp_single", 64'(IFU_vld), 64'd0);

        // ifetch_req during S_R: flagged, PC unchanged
        axi_R_VALID = 1'b0; axi_R_DATA = 64'h55555555_66666666;
        req(1'b0, 64'h0);
        step();
        chk("perr_in_r", 64'(axi_R_READY), 64'd1);
        req(1'b1, 64'h0000_0000_0000_0100);
        chk("perr_set", 64'(proto_err), 64'd1);
        chk("perr_rready", 64'(axi_R_READY), 64'd1);
        axi_R_VALID = 1'b1;
        step();
        chk("perr_vld", 64'(IFU_vld), 64'd1);
        chk("perr_pc", IFU_pc, 64'h8000_100C);
        chk("perr_inst", 64'(IFU_inst), 64'h5555_5555);
        step();
        chk("perr_sticky", 64'(proto_err), 64'd1);
        chk("perr_cnt", inst_cnt, 64'd5);

        // Reset asserted while in S_R with a stray beat
        axi_R_VALID = 1'b0;
        req(1'b0, 64'h0);
        step();
        chk("mrst_in_r", 64'(axi_R_READY), 64'd1);
        rst = 1'b1; axi_R_VALID = 1'b1;
        #1;
        chk("mrst_rready0", 64'(axi_R_READY), 64'd0);
        step();
        chk("mrst_rready1", 64'(axi_R_READY), 64'd0);
        chk("mrst_vld", 64'(IFU_vld), 64'd0);
        chk("mrst_cnt", inst_cnt, 64'd0);
        chk("mrst_perr", 64'(proto_err), 64'd0);
        chk("mrst_pc", IFU_pc, 64'h8000_0000);
        step();
        chk("mrst_vld2", 64'(IFU_vld), 64'd0);
        axi_R_DATA = 64'h00000013_00100093;
        rst = 1'b0;
        #1;
        chk("mrst_araddr", axi_AR_ADDR, 64'h8000_0000);
        wait_vld("mrst", n);
        chk("mrst_fpc", IFU_pc, 64'h8000_0000);
        chk("mrst_finst", 64'(IFU_inst), 64'h0010_0093);
        step();
        chk("mrst_fcnt", inst_cnt, 64'd1);

        // PC wrap at 2^64
        axi_R_DATA = 64'hAAAAAAAA_BBBBBBBB;
        req(1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("wrap_araddr0", axi_AR_ADDR, 64'hFFFF_FFFF_FFFF_FFF8);
        wait_vld("wrap0", n);
        chk("wrap_pc0", IFU_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_inst0", 64'(IFU_inst), 64'hAAAA_AAAA);
        step();
        req(1'b0, 64'h0);
        chk("wrap_araddr1", axi_AR_ADDR, 64'h0);
        wait_vld("wrap1", n);
        chk("wrap_pc1", IFU_pc, 64'h0);
        chk("wrap_inst1", 64'(IFU_inst), 64'hBBBB_BBBB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
